cond_exec_unit: RTL and testbench

Parametrised, pipelined successor to the combinational condition checker. It holds an architectural NZCV flag register and accepts a stream of predicated operations over a valid/ready handshake. Each operation can optionally compare two signed operands to produce NZCV flags. The block evaluates one of 16 condition codes and returns a registered execute/skip decision one cycle later. It sits between decode and the ALU writeback enable and keeps saturating executed/skipped statistics.

---
 rtl/cond_pkg.sv | 62 ++++++
 rtl/cond_exec_unit_nzcv_cmp.sv | 24 ++
 rtl/cond_exec_unit.sv | 153 +++++++++++++++
 tb/tb_cond_exec_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution path: condition codes,
// NZCV bit positions and the condition evaluator.
package cond_pkg;

  typedef enum logic [3:0] {
    COND_AL = 4'd0,
    COND_EQ = 4'd1,
    COND_GT = 4'd2,
    COND_LT = 4'd3,
    COND_GE = 4'd4,
    COND_LE = 4'd5,
    COND_HI = 4'd6,
    COND_LO = 4'd7,
    COND_HS = 4'd8,
    COND_NE = 4'd9,
    COND_LS = 4'd10,
    COND_MI = 4'd11,
    COND_PL = 4'd12,
    COND_VS = 4'd13,
    COND_VC = 4'd14,
    COND_NV = 4'd15
  } cond_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  function automatic logic cond_eval(input cond_e cond, input logic [3:0] nzcv);
    logic n_s;
    logic z_s;
    logic c_s;
    logic v_s;
    logic res_s;
    n_s   = nzcv[N_IDX];
    z_s   = nzcv[Z_IDX];
    c_s   = nzcv[C_IDX];
    v_s   = nzcv[V_IDX];
    res_s = 1'b0;
    case (cond)
      COND_AL: res_s = 1'b1;
      COND_EQ: res_s = z_s;
      COND_GT: res_s = !z_s && (n_s == v_s);
      COND_LT: res_s = (n_s != v_s);
      COND_GE: res_s = (n_s == v_s);
      COND_LE: res_s = z_s || (n_s != v_s);
      COND_HI: res_s = c_s && !z_s;
      COND_LO: res_s = !c_s;
      COND_HS: res_s = c_s;
      COND_NE: res_s = !z_s;
      COND_LS: res_s = !c_s || z_s;
      COND_MI: res_s = n_s;
      COND_PL: res_s = !n_s;
      COND_VS: res_s = v_s;
      COND_VC: res_s = !v_s;
      COND_NV: res_s = 1'b0;
      default: res_s = 1'b0;
    endcase
    return res_s;
  endfunction

endpackage

// File: rtl/cond_exec_unit_nzcv_cmp.sv
// Combinational A-B comparator producing NZCV; shared with the ALU flag path.
module nzcv_cmp
  import cond_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [3:0]        nzcv_o
);

  logic [DATA_W:0] diff_s;

  // Subtract as A + ~B + 1 so the carry out reads directly as "no borrow".
  always_comb begin
    diff_s = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_W{1'b0}}, 1'b1};
    nzcv_o        = 4'b0000;
    nzcv_o[N_IDX] = diff_s[DATA_W-1];
    nzcv_o[Z_IDX] = (diff_s[DATA_W-1:0] == {DATA_W{1'b0}});
    nzcv_o[C_IDX] = diff_s[DATA_W];
    nzcv_o[V_IDX] = (a_i[DATA_W-1] != b_i[DATA_W-1]) && (diff_s[DATA_W-1] != a_i[DATA_W-1]);
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Pipelined predicate evaluator: NZCV flag register, one-deep output stage with
// valid/ready handshake, and saturating executed/skipped statistics.
module cond_exec_unit
  import cond_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] FLAG_RST = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cmp,
  input  logic              in_set_flags,
  input  logic [3:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_execute,
  output logic [3:0]        out_flags,
  input  logic              flag_wr_en,
  input  logic [3:0]        flag_wr_data,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  exec_cnt,
  output logic [CNT_W-1:0]  skip_cnt,
  input  logic              cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic             out_execute_q, out_execute_d;
  logic [3:0]       out_flags_q, out_flags_d;
  logic [3:0]       flag_reg_q, flag_reg_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  logic       accept_s;
  logic       out_hs_s;
  logic [3:0] cmp_flags_s;
  logic [3:0] eff_flags_s;
  logic [3:0] derived_s;
  logic       cond_pass_s;

  nzcv_cmp #(.DATA_W(DATA_W)) u_cmp (
    .a_i    (in_a),
    .b_i    (in_b),
    .nzcv_o (cmp_flags_s)
  );

  // Handshake and flag selection; a same-cycle ALU write is forwarded.
  always_comb begin
    in_ready    = !out_valid_q || out_ready;
    accept_s    = in_valid && in_ready;
    out_hs_s    = out_valid_q && out_ready;
    eff_flags_s = flag_reg_q;
    if (flag_wr_en) begin
      eff_flags_s = flag_wr_data;
    end else begin
      eff_flags_s = flag_reg_q;
    end
    if (in_cmp) begin
      derived_s = cmp_flags_s;
    end else begin
      derived_s = eff_flags_s;
    end
    cond_pass_s = cond_eval(cond_e'(in_cond), derived_s);
  end

  // Output stage: load on accept, drop valid once consumed, hold while stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_execute_d = out_execute_q;
    out_flags_d   = out_flags_q;
    if (accept_s) begin
      out_valid_d   = 1'b1;
      out_execute_d = cond_pass_s;
      out_flags_d   = derived_s;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Flag register: a flag-setting accepted op outranks the ALU write port.
  always_comb begin
    flag_reg_d = flag_reg_q;
    if (accept_s && in_set_flags) begin
      flag_reg_d = derived_s;
    end else if (flag_wr_en) begin
      flag_reg_d = flag_wr_data;
    end else begin
      flag_reg_d = flag_reg_q;
    end
  end

  // Statistics count consumed results only and stick at all-ones.
  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (cnt_clr) begin
      exec_cnt_d = {CNT_W{1'b0}};
      skip_cnt_d = {CNT_W{1'b0}};
    end else if (out_hs_s) begin
      if (out_execute_q) begin
        if (exec_cnt_q != CNT_MAX) begin
          exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end else begin
          exec_cnt_d = exec_cnt_q;
        end
      end else begin
        if (skip_cnt_q != CNT_MAX) begin
          skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end else begin
          skip_cnt_d = skip_cnt_q;
        end
      end
    end else begin
      exec_cnt_d = exec_cnt_q;
      skip_cnt_d = skip_cnt_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      out_execute_q <= 1'b0;
      out_flags_q   <= 4'b0000;
      flag_reg_q    <= FLAG_RST;
      exec_cnt_q    <= {CNT_W{1'b0}};
      skip_cnt_q    <= {CNT_W{1'b0}};
    end else begin
      out_valid_q   <= out_valid_d;
      out_execute_q <= out_execute_d;
      out_flags_q   <= out_flags_d;
      flag_reg_q    <= flag_reg_d;
      exec_cnt_q    <= exec_cnt_d;
      skip_cnt_q    <= skip_cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_execute = out_execute_q;
  assign out_flags   = out_flags_q;
  assign flags_q     = flag_reg_q;
  assign exec_cnt    = exec_cnt_q;
  assign skip_cnt    = skip_cnt_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Self-checking bench for cond_exec_unit: hand-derived vector table, a
// reference model with scoreboard, and directed stall/saturation/reset cases.
module tb_cond_exec_unit;

  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_cmp;
  logic          in_set_flags;
  logic [3:0]    in_cond;
  logic          out_valid;
  logic          out_ready;
  logic          out_execute;
  logic [3:0]    out_flags;
  logic          flag_wr_en;
  logic [3:0]    flag_wr_data;
  logic [3:0]    flags_q;
  logic [CW-1:0] exec_cnt;
  logic [CW-1:0] skip_cnt;
  logic          cnt_clr;

  cond_exec_unit #(.DATA_W(DW), .CNT_W(CW), .FLAG_RST(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cmp(in_cmp), .in_set_flags(in_set_flags),
    .in_cond(in_cond), .out_valid(out_valid), .out_ready(out_ready),
    .out_execute(out_execute), .out_flags(out_flags), .flag_wr_en(flag_wr_en),
    .flag_wr_data(flag_wr_data), .flags_q(flags_q), .exec_cnt(exec_cnt),
    .skip_cnt(skip_cnt), .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       exec;
    logic [3:0] flags;
  } res_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          cmp;
    logic          set;
    logic [3:0]    cond;
    logic          exp_exec;
    logic [3:0]    exp_flags;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  res_t sb_q[$];
  logic [3:0] m_flags;
  logic       m_valid;
  int         m_exec;
  int         m_skip;
  localparam int CNT_MAX = (1 << CW) - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent flag model: arithmetic on wide signed/unsigned integers.
  function automatic logic [3:0] model_cmp(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] d;
    longint sa, sb, r;
    logic n, z, c, v;
    d  = a - b;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sa - sb;
    n  = d[DW-1];
    z  = (a == b);
    c  = (a >= b);
    v  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {n, z, c, v};
  endfunction

  function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return 1'b1;
      4'd1:  return z;
      4'd2:  return !z && (n == v);
      4'd3:  return n ^ v;
      4'd4:  return !(n ^ v);
      4'd5:  return z | (n ^ v);
      4'd6:  return c & ~z;
      4'd7:  return ~c;
      4'd8:  return c;
      4'd9:  return ~z;
      4'd10: return ~c | z;
      4'd11: return n;
      4'd12: return ~n;
      4'd13: return v;
      4'd14: return ~v;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cmp,
                        input logic set, input logic [3:0] cc);
    in_valid = 1'b1; in_a = a; in_b = b; in_cmp = cmp; in_set_flags = set; in_cond = cc;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic tick(input bit use_exp, input res_t exp_r);
    logic [3:0] eff, der;
    logic       acc, hs;
    res_t       e;
    #1;
    check("in_ready", in_ready, !m_valid || out_ready);
    check("out_valid", out_valid, m_valid);
    hs = m_valid && out_ready;
    e  = '0;
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty actual=1 required=0");
      end else begin
        e = sb_q[0];
        check("out_execute", out_execute, e.exec);
        check("out_flags", out_flags, e.flags);
        if (hs) void'(sb_q.pop_front());
      end
    end
    acc = in_valid && (!m_valid || out_ready);
    eff = flag_wr_en ? flag_wr_data : m_flags;
    der = in_cmp ? model_cmp(in_a, in_b) : eff;
    if (acc) begin
      if (use_exp) sb_q.push_back(exp_r);
      else sb_q.push_back({model_cond(in_cond, der), der});
    end
    m_valid = acc ? 1'b1 : (out_ready ? 1'b0 : m_valid);
    if (acc && in_set_flags) m_flags = der;
    else if (flag_wr_en) m_flags = flag_wr_data;
    if (cnt_clr) begin
      m_exec = 0; m_skip = 0;
    end else if (hs) begin
      if (e.exec) m_exec = (m_exec < CNT_MAX) ? m_exec + 1 : m_exec;
      else m_skip = (m_skip < CNT_MAX) ? m_skip + 1 : m_skip;
    end
    @(posedge clk);
    #1;
    check("flags_q", flags_q, m_flags);
    check("exec_cnt", exec_cnt, m_exec);
    check("skip_cnt", skip_cnt, m_skip);
    @(negedge clk);
  endtask

  vec_t vecs[14];
  res_t nul;

  initial begin
    nul = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cmp = 1'b0;
    in_set_flags = 1'b0; in_cond = 4'd0; out_ready = 1'b1; flag_wr_en = 1'b0;
    flag_wr_data = 4'b0000; cnt_clr = 1'b0;
    m_flags = 4'b0000; m_valid = 1'b0; m_exec = 0; m_skip = 0;

    vecs[0]  = '{32'd5, 32'd5, 1'b1, 1'b1, 4'd1, 1'b1, 4'b0110};
    vecs[1]  = '{32'd0, 32'd0, 1'b0, 1'b0, 4'd9, 1'b0, 4'b0110};
    vecs[2]  = '{32'h8000_0000, 32'd1, 1'b1, 1'b0, 4'd2, 1'b0, 4'b0011};
    vecs[3]  = '{32'h8000_0000, 32'd1, 1'b1, 1'b0, 4'd3, 1'b1, 4'b0011};
    vecs[4]  = '{32'h8000_0000, 32'd1, 1'b1, 1'b0, 4'd6, 1'b1, 4'b0011};
    vecs[5]  = '{32'd1, 32'd2, 1'b1, 1'b0, 4'd7, 1'b1, 4'b1000};
    vecs[6]  = '{32'd1, 32'd2, 1'b1, 1'b0, 4'd10, 1'b1, 4'b1000};
    vecs[7]  = '{32'd1, 32'd2, 1'b1, 1'b0, 4'd15, 1'b0, 4'b1000};
    vecs[8]  = '{32'd1, 32'd2, 1'b1, 1'b0, 4'd0, 1'b1, 4'b1000};
    vecs[9]  = '{32'd0, 32'd0, 1'b0, 1'b0, 4'd1, 1'b1, 4'b0110};
    vecs[10] = '{32'hFFFF_FFFD, 32'd2, 1'b1, 1'b1, 4'd3, 1'b1, 4'b1010};
    vecs[11] = '{32'd0, 32'd0, 1'b0, 1'b0, 4'd4, 1'b0, 4'b1010};
    vecs[12] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd13, 1'b1, 4'b1001};
    vecs[13] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd5, 1'b0, 4'b1001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_flags_q", flags_q, 4'b0000);
    check("rst_out_flags", out_flags, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back table with hand-derived results.
    for (int i = 0; i < 14; i++) begin
      set_op(vecs[i].a, vecs[i].b, vecs[i].cmp, vecs[i].set, vecs[i].cond);
      tick(1'b1, {vecs[i].exp_exec, vecs[i].exp_flags});
    end
    in_valid = 1'b0;
    tick(1'b0, nul);
    check("table_drain", sb_q.size(), 0);

    // Accept with set_flags beats a concurrent ALU write; then forwarding.
    set_op(32'd5, 32'd5, 1'b1, 1'b1, 4'd1);
    flag_wr_en = 1'b1; flag_wr_data = 4'b1010;
    tick(1'b1, {1'b1, 4'b0110});
    set_op(32'd0, 32'd0, 1'b0, 1'b0, 4'd11);
    flag_wr_data = 4'b1000;
    tick(1'b1, {1'b1, 4'b1000});
    flag_wr_en = 1'b0;

    // Backpressure: three stalled cycles with a flag-setting op offered.
    out_ready = 1'b0;
    set_op(32'd1, 32'd2, 1'b1, 1'b1, 4'd7);
    tick(1'b1, {1'b1, 4'b1000});
    set_op(32'd3, 32'd3, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < 3; i++) tick(1'b0, nul);
    check("stall_flags_q", flags_q, 4'b1000);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(32'(i * 7), 32'(i * 3 + 1), 1'b1, 1'b0, 4'(i + 2));
      tick(1'b0, nul);
    end
    in_valid = 1'b0;
    tick(1'b0, nul);
    check("bp_drain", sb_q.size(), 0);

    // Randomised traffic with random consumer stalls and ALU writes.
    for (int i = 0; i < 60; i++) begin
      set_op($urandom, ($urandom_range(0, 3) == 0) ? in_a : $urandom, 1'($urandom),
             1'($urandom), 4'($urandom));
      in_valid     = 1'($urandom_range(0, 3) != 0);
      out_ready    = 1'($urandom_range(0, 2) != 0);
      flag_wr_en   = 1'($urandom_range(0, 3) == 0);
      flag_wr_data = 4'($urandom);
      tick(1'b0, nul);
    end
    in_valid = 1'b0; flag_wr_en = 1'b0; out_ready = 1'b1;
    tick(1'b0, nul);
    tick(1'b0, nul);

    // Saturation of the executed counter, then clear with a concurrent pass.
    for (int i = 0; i < 20; i++) begin
      set_op(32'd0, 32'd0, 1'b0, 1'b0, 4'd0);
      tick(1'b1, {1'b1, m_flags});
    end
    check("exec_saturated", exec_cnt, CNT_MAX);
    cnt_clr = 1'b1;
    tick(1'b1, {1'b1, m_flags});
    cnt_clr = 1'b0;
    check("clr_exec_cnt", exec_cnt, 0);

    // Reset mid-stream with a result pending.
    set_op(32'd1, 32'd2, 1'b1, 1'b1, 4'd0);
    tick(1'b1, {1'b1, 4'b1000});
    in_valid = 1'b0;
    #2;
    check("pre_rst_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_flags_q", flags_q, 4'b0000);
    check("mid_rst_exec_cnt", exec_cnt, 0);
    check("mid_rst_skip_cnt", skip_cnt, 0);
    check("mid_rst_out_execute", out_execute, 1'b0);
    sb_q.delete();
    m_flags = 4'b0000; m_valid = 1'b0; m_exec = 0; m_skip = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_op(32'd9, 32'd4, 1'b1, 1'b0, 4'd2);
    tick(1'b1, {1'b1, 4'b0010});
    in_valid = 1'b0;
    tick(1'b0, nul);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
